// File: rtl/fetch_ghr_ckpt.sv
// fetch_ghr_ckpt: checkpoint queue of speculative global history, one entry per
// in-flight predicted branch, restoring the GHR on a mispredict.
module fetch_ghr_ckpt #(
   parameter int DEPTH = 8,
   parameter int GHR_W = 8,
   localparam int TW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [GHR_W-1:0] ghr_rdata,
   output logic             ghr_wen,
   output logic [GHR_W-1:0] ghr_wdata,
   input  logic             pred_valid,
   input  logic             pred_taken,
   output logic             pred_ready,
   output logic [TW-1:0]    pred_tag,
   input  logic             resolve_valid,
   input  logic [TW-1:0]    resolve_tag,
   input  logic             resolve_mispredict,
   input  logic             resolve_taken,
   input  logic             commit_valid,
   output logic [TW:0]      ckpt_count
);
   localparam logic [TW:0] ONE = (TW+1)'(1);
   logic [GHR_W-1:0] ckpt_q [DEPTH];
   logic [TW:0]      head_q, head_d, tail_q, tail_d, count;
   logic [TW-1:0]    offs;
   logic             tag_ok, flush, accept, commit;
   assign count  = tail_q - head_q;
   assign offs   = resolve_tag - head_q[TW-1:0];
   assign tag_ok = {1'b0, offs} < count;
   assign flush  = ~reset & resolve_valid & resolve_mispredict & tag_ok;
   // count never exceeds DEPTH, so its top bit alone means full
   assign pred_ready = ~reset & ~count[TW] & ~flush;
   assign accept     = pred_valid & pred_ready;
   assign commit     = ~reset & commit_valid & (count != '0);
   assign pred_tag   = reset ? '0 : tail_q[TW-1:0];
   assign ckpt_count = reset ? '0 : count;
   assign ghr_wen    = accept | flush;
   assign ghr_wdata  = flush  ? {ckpt_q[resolve_tag][GHR_W-2:0], resolve_taken} :
                       accept ? {ghr_rdata[GHR_W-2:0], pred_taken} : ghr_rdata;
   assign head_d = commit ? head_q + ONE : head_q;
   assign tail_d = flush  ? head_q + {1'b0, offs} + ONE :
                   accept ? tail_q + ONE : tail_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end
   always_ff @(posedge clk) begin
      if (accept) ckpt_q[tail_q[TW-1:0]] <= ghr_rdata;
   end
endmodule

// File: tb/tb_fetch_ghr_ckpt.sv
// tb_fetch_ghr_ckpt: directed and random stimulus checked against a queue model
// of in-flight branches; the bench also plays the external history register.
module tb_fetch_ghr_ckpt;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] ghr_rdata, ghr_wdata;
   logic       ghr_wen, pred_valid, pred_taken, pred_ready;
   logic [2:0] pred_tag, resolve_tag;
   logic       resolve_valid, resolve_mispredict, resolve_taken, commit_valid;
   logic [3:0] ckpt_count;
   int total = 0, bad = 0;
   int hd = 0;
   logic [7:0] q[$];
   logic [7:0] ghr = 8'h00;
   assign ghr_rdata = ghr;
   always #5 clk = ~clk;
   fetch_ghr_ckpt dut (
      .clk(clk), .reset(reset), .ghr_rdata(ghr_rdata), .ghr_wen(ghr_wen),
      .ghr_wdata(ghr_wdata), .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_ready(pred_ready), .pred_tag(pred_tag), .resolve_valid(resolve_valid),
      .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
      .resolve_taken(resolve_taken), .commit_valid(commit_valid), .ckpt_count(ckpt_count)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic drive(input bit r, input bit pv, input bit pt, input bit rv, input bit rm,
                        input bit rt, input logic [2:0] tg, input bit cv);
      @(negedge clk);
      reset = r; pred_valid = pv; pred_taken = pt; resolve_valid = rv;
      resolve_mispredict = rm; resolve_taken = rt; resolve_tag = tg; commit_valid = cv;
      #1;
   endtask
   // compare against the model for the inputs currently driven, then advance one clock
   task automatic tick();
      int cnt, off;
      bit fl, rdy, acc, cm, wen;
      logic [7:0] w;
      cnt = q.size();
      off = (int'(resolve_tag) - (hd % 8) + 8) % 8;
      fl  = !reset && resolve_valid && resolve_mispredict && off < cnt;
      rdy = !reset && cnt < 8 && !fl;
      acc = pred_valid && rdy;
      cm  = !reset && commit_valid && cnt > 0;
      wen = acc || fl;
      w   = fl ? {q[off][6:0], resolve_taken} : acc ? {ghr[6:0], pred_taken} : ghr;
      chk("pred_ready", 32'(pred_ready), 32'(rdy));
      chk("pred_tag", 32'(pred_tag), reset ? 0 : 32'((hd + cnt) % 8));
      chk("ckpt_count", 32'(ckpt_count), reset ? 0 : 32'(cnt));
      chk("ghr_wen", 32'(ghr_wen), 32'(wen));
      if (!reset) chk("ghr_wdata", 32'(ghr_wdata), 32'(w));
      @(posedge clk);
      #1;
      if (reset) begin
         q.delete();
         hd = 0;
      end else begin
         if (fl) q = q[0:off];
         if (acc) q.push_back(ghr);
         if (cm) begin
            void'(q.pop_front());
            hd++;
         end
         ghr = w;
      end
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 3'd0, 0);
   endtask
   task automatic do_reset();
      drive(1, 1, 1, 1, 1, 1, 3'd0, 1);
      tick();
   endtask
   task automatic accepts(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 1, 1'($urandom), 0, 0, 0, 3'd0, 0);
         tick();
      end
   endtask
   initial begin
      do_reset();
      do_reset();
      ghr = 8'h00;
      drive(0, 1, 1, 0, 0, 0, 3'd0, 0);
      chk("first_ready", 32'(pred_ready), 1);
      chk("first_tag", 32'(pred_tag), 0);
      chk("first_wen", 32'(ghr_wen), 1);
      chk("first_wdata", 32'(ghr_wdata), 32'h01);
      tick();
      idle();
      chk("first_count", 32'(ckpt_count), 1);
      tick();
      accepts(7);
      drive(0, 1, 1, 0, 0, 0, 3'd0, 0);
      chk("full_count", 32'(ckpt_count), 8);
      chk("full_stall", 32'(pred_ready), 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 3'd0, 1);
      tick();
      idle();
      chk("wrap_ready", 32'(pred_ready), 1);
      chk("wrap_tag", 32'(pred_tag), 0);
      tick();
      do_reset();
      ghr = 8'h2D;
      drive(0, 1, 0, 0, 0, 0, 3'd0, 0); tick();
      drive(0, 1, 1, 0, 0, 0, 3'd0, 0); tick();
      drive(0, 1, 0, 0, 0, 0, 3'd0, 0); tick();
      drive(0, 1, 1, 0, 0, 0, 3'd0, 0); tick();
      drive(0, 0, 0, 1, 1, 1, 3'd1, 0);
      chk("flush_wdata", 32'(ghr_wdata), 32'hB5);
      chk("flush_wen", 32'(ghr_wen), 1);
      tick();
      idle();
      chk("flush_count", 32'(ckpt_count), 2);
      chk("flush_tag", 32'(pred_tag), 2);
      tick();
      do_reset();
      accepts(4);
      drive(0, 1, 1, 1, 1, 0, 3'd2, 0);
      chk("flush_blocks_pred", 32'(pred_ready), 0);
      tick();
      idle();
      chk("flush_pred_count", 32'(ckpt_count), 3);
      tick();
      do_reset();
      accepts(3);
      drive(0, 0, 0, 1, 1, 1, 3'd0, 1);
      tick();
      idle();
      chk("cf_count", 32'(ckpt_count), 0);
      chk("cf_tag", 32'(pred_tag), 1);
      tick();
      do_reset();
      accepts(2);
      drive(0, 0, 0, 1, 1, 1, 3'd5, 0);
      chk("badtag_wen", 32'(ghr_wen), 0);
      tick();
      idle();
      chk("badtag_count", 32'(ckpt_count), 2);
      tick();
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 3'd0, 1);
      chk("empty_commit_wen", 32'(ghr_wen), 0);
      tick();
      idle();
      chk("empty_commit_count", 32'(ckpt_count), 0);
      tick();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(63) == 0, $urandom_range(9) < 6, 1'($urandom),
               $urandom_range(9) < 4, $urandom_range(9) < 4, 1'($urandom),
               3'($urandom), $urandom_range(9) < 3);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_ghr_ckpt.md
FETCH_GHR_CKPT -- requirements
Module: fetch_ghr_ckpt

Interface
REQ-001 SHALL have parameter DEPTH, default 8, checkpoint queue entries (power of two; tag width log2(DEPTH)=3).
REQ-002 SHALL have parameter GHR_W, default 8, global history width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- ghr_rdata  in  8  current committed-speculative GHR value from the history register
- ghr_wen  out  1  write enable to the history register
- ghr_wdata  out  8  next GHR value
- pred_valid  in  1  fetch presents a predicted conditional branch
- pred_taken  in  1  predicted direction
- pred_ready  out  1  checkpoint accepted this cycle
- pred_tag  out  3  checkpoint index given to the accepted branch
- resolve_valid  in  1  branch resolution from execute
- resolve_tag  in  3  checkpoint index being resolved
- resolve_mispredict  in  1  resolved direction differs from prediction
- resolve_taken  in  1  actual direction
- commit_valid  in  1  oldest in-flight branch retires
- ckpt_count  out  4  occupied entries, 0..8

Function
REQ-005 State: checkpoint array ckpt[0..7] of 8 bits, head and tail pointers of 4 bits (3-bit index plus wrap bit), count = tail - head (4-bit).
REQ-006 Tag validity: resolve_tag valid iff ((resolve_tag - head[2:0]) mod 8) < count; invalid-tag resolves SHALL be ignored entirely.
REQ-007 Flush = resolve_valid & resolve_mispredict & valid tag.
REQ-008 pred_ready SHALL be combinational: (count < 8) & ~flush, count taken before any same-cycle commit.
REQ-009 pred_tag SHALL equal tail[2:0] every cycle.
REQ-010 Accept (pred_valid & pred_ready): ckpt[tail[2:0]] <= ghr_rdata; tail <= tail+1; ghr_wen=1; ghr_wdata={ghr_rdata[6:0], pred_taken}.
REQ-011 Flush: ghr_wen=1; ghr_wdata={ckpt[resolve_tag][6:0], resolve_taken}; tail <= head + ((resolve_tag - head[2:0]) mod 8) + 1, discarding all younger entries; the flushed entry itself remains in-flight.
REQ-012 Flush SHALL take priority over a same-cycle prediction; the prediction is not accepted (pred_ready=0).
REQ-013 Resolve with resolve_mispredict=0 SHALL change no state and drive ghr_wen=0.
REQ-014 commit_valid with count>0: head <= head+1; with count=0: ignored.
REQ-015 Commit and flush in one cycle SHALL both apply; commit uses pre-flush head; commit of the flushed entry itself is legal (result count = flushed-span - 1).
REQ-016 Commit and accept in one cycle SHALL both apply; count unchanged.
REQ-017 ghr_wen/ghr_wdata SHALL be combinational; new GHR value is visible on ghr_rdata one cycle after the write cycle.
REQ-018 When neither accept nor flush occurs, ghr_wen=0 and ghr_wdata=ghr_rdata.
REQ-019 Pointer arithmetic SHALL wrap modulo 16 (index modulo 8); full = count==8, empty = count==0.
REQ-020 ckpt_count SHALL be registered-state count (no same-cycle effects).

Reset
REQ-021 While reset=1: head=tail=0, ckpt_count=0, pred_ready=0, ghr_wen=0; pred_tag=0; checkpoint contents need not be cleared.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight checkpoints at the next edge; inputs ignored during reset.
REQ-023 First cycle after reset deassertion: pred_ready=1, ckpt_count=0.

Verification
REQ-024 Reset then pred_valid=1,taken=1 with ghr_rdata=0x00 -> pred_ready=1, pred_tag=0, ghr_wen=1, ghr_wdata=0x01; next cycle ckpt_count=1.
REQ-025 Eight accepts without commit -> ckpt_count=8, pred_ready=0; ninth pred_valid stalls; one commit_valid -> next cycle pred_ready=1, pred_tag=0 (wrap).
REQ-026 Entries tags 0..3 with ckpt[1]=0x5A; resolve tag=1, mispredict=1, taken=1 -> ghr_wdata=0xB5, ghr_wen=1; next cycle ckpt_count=2, pred_tag=2.
REQ-027 Same-cycle flush (tag 2) and pred_valid -> pred_ready=0, ghr_wdata from ckpt[2]; prediction not recorded.
REQ-028 count=3, head=0; same-cycle commit and flush tag 0 -> next cycle ckpt_count=0, head=1, tail=1.
REQ-029 Invalid-tag mispredict (tag 5, count=2, head=0) and commit_valid with count=0 -> no state change, ghr_wen=0.
